// File: rtl/dvs_event_crop_ctrl.sv
// DVS event crop controller: passes events inside a reconfigurable window, drains before reloading it.
// Optional drop counter enabled by defining DVS_CROP_DROP_COUNT_EN.
package dvs_ravens_pkg;
  localparam int unsigned DVS_X_ADDR_BITS = 8;
  localparam int unsigned DVS_Y_ADDR_BITS = 8;
endpackage

module dvs_event_crop_ctrl
  import dvs_ravens_pkg::*;
#(
  parameter int unsigned DEF_CORNER_X  = 0,
  parameter int unsigned DEF_CORNER_Y  = 0,
  parameter int unsigned DEF_WIDTH     = 100,
  parameter int unsigned DEF_HEIGHT    = 100,
  parameter int unsigned DROP_CNT_BITS = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DVS_X_ADDR_BITS-1:0] in_x,
  input  logic [DVS_Y_ADDR_BITS-1:0] in_y,
  input  logic                       in_pol,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DVS_X_ADDR_BITS-1:0] out_x,
  output logic [DVS_Y_ADDR_BITS-1:0] out_y,
  output logic                       out_pol,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [DVS_X_ADDR_BITS-1:0] cfg_corner_x,
  input  logic [DVS_X_ADDR_BITS-1:0] cfg_width,
  input  logic [DVS_Y_ADDR_BITS-1:0] cfg_corner_y,
  input  logic [DVS_Y_ADDR_BITS-1:0] cfg_height,
  output logic                       busy,
  output logic [DROP_CNT_BITS-1:0]   drop_count
);

  localparam int unsigned XW  = DVS_X_ADDR_BITS;
  localparam int unsigned YW  = DVS_Y_ADDR_BITS;
  localparam int unsigned XW1 = XW + 1;
  localparam int unsigned YW1 = YW + 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOAD} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] act_cx_q, act_cx_d, act_w_q, act_w_d;
  logic [YW-1:0] act_cy_q, act_cy_d, act_h_q, act_h_d;
  logic          out_valid_q, out_valid_d;
  logic [XW-1:0] out_x_q, out_x_d;
  logic [YW-1:0] out_y_q, out_y_d;
  logic          out_pol_q, out_pol_d;

  logic           accept;
  logic           in_win;
  logic [XW1-1:0] x_hi;
  logic [YW1-1:0] y_hi;

  // Bounds one bit wider so corner+size cannot wrap
  always_comb begin
    x_hi   = XW1'(act_cx_q) + XW1'(act_w_q);
    y_hi   = YW1'(act_cy_q) + YW1'(act_h_q);
    in_win = (in_x >= act_cx_q) && (XW1'(in_x) < x_hi) &&
             (in_y >= act_cy_q) && (YW1'(in_y) < y_hi);
  end

  assign in_ready  = (state_q == ST_RUN) && !cfg_valid && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign cfg_ready = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_RUN);
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_pol   = out_pol_q;

  always_comb begin
    state_d     = state_q;
    act_cx_d    = act_cx_q;
    act_cy_d    = act_cy_q;
    act_w_d     = act_w_q;
    act_h_d     = act_h_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_pol_d   = out_pol_q;

    case (state_q)
      ST_RUN:   if (cfg_valid) state_d = ST_DRAIN;
      ST_DRAIN: if (!out_valid_q || out_ready) state_d = ST_LOAD;
      ST_LOAD: begin
        act_cx_d = cfg_corner_x;
        act_cy_d = cfg_corner_y;
        act_w_d  = cfg_width;
        act_h_d  = cfg_height;
        state_d  = ST_RUN;
      end
      default:  state_d = ST_RUN;
    endcase

    // Out-of-window events are consumed without touching the output register
    if (accept && in_win) begin
      out_valid_d = 1'b1;
      out_x_d     = in_x;
      out_y_d     = in_y;
      out_pol_d   = in_pol;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      act_cx_q    <= XW'(DEF_CORNER_X);
      act_cy_q    <= YW'(DEF_CORNER_Y);
      act_w_q     <= XW'(DEF_WIDTH);
      act_h_q     <= YW'(DEF_HEIGHT);
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_pol_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_cx_q    <= act_cx_d;
      act_cy_q    <= act_cy_d;
      act_w_q     <= act_w_d;
      act_h_q     <= act_h_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_pol_q   <= out_pol_d;
    end
  end

`ifdef DVS_CROP_DROP_COUNT_EN
  logic [DROP_CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of accepted out-of-window events
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && !in_win && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_BITS'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_dvs_event_crop_ctrl.sv
// Directed self-checking bench for dvs_event_crop_ctrl.
module tb_dvs_event_crop_ctrl;
  import dvs_ravens_pkg::*;

  localparam int unsigned XW = DVS_X_ADDR_BITS;
  localparam int unsigned YW = DVS_Y_ADDR_BITS;
  localparam int unsigned DCB = 4;
`ifdef DVS_CROP_DROP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_pol;
  logic [XW-1:0] in_x;
  logic [YW-1:0] in_y;
  logic          out_valid, out_ready, out_pol;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          cfg_valid, cfg_ready, busy;
  logic [XW-1:0] cfg_corner_x, cfg_width;
  logic [YW-1:0] cfg_corner_y, cfg_height;
  logic [DCB-1:0] drop_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_drops = 0;

  always #5 clk = ~clk;

  dvs_event_crop_ctrl #(.DROP_CNT_BITS(DCB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_pol(in_pol),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_pol(out_pol),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_corner_x(cfg_corner_x), .cfg_width(cfg_width),
    .cfg_corner_y(cfg_corner_y), .cfg_height(cfg_height),
    .busy(busy), .drop_count(drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_drop();
    if (!CNT_EN) return 32'd0;
    return (exp_drops > 15) ? 32'd15 : 32'(exp_drops);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input int x, input int y, input logic p);
    in_valid = 1'b1;
    in_x     = XW'(x);
    in_y     = YW'(y);
    in_pol   = p;
  endtask

  task automatic cfg(input int cx, input int cy, input int w, input int h);
    cfg_valid    = 1'b1;
    cfg_corner_x = XW'(cx);
    cfg_corner_y = YW'(cy);
    cfg_width    = XW'(w);
    cfg_height   = YW'(h);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_pol = 1'b0;
    out_ready = 1'b0; cfg_valid = 1'b0;
    cfg_corner_x = '0; cfg_corner_y = '0; cfg_width = '0; cfg_height = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_x", 32'(out_x), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 0);
    chk("rst_drop", 32'(drop_count), 0);
    rst_n = 1'b1;
    tick();

    // Default window, continuous out_ready
    out_ready = 1'b1;
    ev(99, 99, 1'b0);
    #1 chk("def_in_ready", 32'(in_ready), 1);
    tick();
    chk("def_pass_valid", 32'(out_valid), 1);
    chk("def_pass_x", 32'(out_x), 99);
    chk("def_pass_y", 32'(out_y), 99);
    ev(100, 5, 1'b1);
    tick();
    exp_drops++;
    chk("def_drop_valid", 32'(out_valid), 0);
    chk("def_drop_cnt", 32'(drop_count), exp_drop());
    chk("def_drop_hold_x", 32'(out_x), 99);

    // Backpressure: three events in order, none lost
    out_ready = 1'b0;
    ev(1, 1, 1'b1);
    tick();
    chk("bp_first_valid", 32'(out_valid), 1);
    chk("bp_first_x", 32'(out_x), 1);
    ev(2, 2, 1'b0);
    #1 chk("bp_stall_ready", 32'(in_ready), 0);
    tick();
    tick();
    chk("bp_hold_x", 32'(out_x), 1);
    chk("bp_hold_pol", 32'(out_pol), 1);
    chk("bp_hold_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 1);
    tick();
    chk("bp_second_x", 32'(out_x), 2);
    chk("bp_second_pol", 32'(out_pol), 0);
    ev(3, 3, 1'b1);
    tick();
    chk("bp_third_x", 32'(out_x), 3);
    chk("bp_third_valid", 32'(out_valid), 1);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", 32'(out_valid), 0);

    // Reconfigure while output is stalled
    out_ready = 1'b0;
    ev(5, 5, 1'b0);
    tick();
    in_valid = 1'b0;
    cfg(10, 10, 5, 5);
    #1 chk("cfg_blocks_input", 32'(in_ready), 0);
    tick();
    chk("drain_busy", 32'(busy), 1);
    chk("drain_cfg_ready", 32'(cfg_ready), 0);
    tick();
    chk("drain_stays_busy", 32'(busy), 1);
    chk("drain_hold_x", 32'(out_x), 5);
    out_ready = 1'b1;
    tick();
    chk("load_cfg_ready", 32'(cfg_ready), 1);
    chk("load_busy", 32'(busy), 1);
    chk("load_out_empty", 32'(out_valid), 0);
    chk("load_in_ready", 32'(in_ready), 0);
    tick();
    chk("run_cfg_ready", 32'(cfg_ready), 0);
    chk("run_busy", 32'(busy), 0);
    cfg_valid = 1'b0;
    ev(14, 14, 1'b1);
    tick();
    chk("newwin_pass_valid", 32'(out_valid), 1);
    chk("newwin_pass_x", 32'(out_x), 14);
    ev(15, 10, 1'b0);
    tick();
    exp_drops++;
    chk("newwin_drop_valid", 32'(out_valid), 0);
    chk("newwin_drop_cnt", 32'(drop_count), exp_drop());

    // Wrap-free bounds at max corner; also empty-output passes through DRAIN
    in_valid = 1'b0;
    cfg((1 << XW) - 1, 0, (1 << XW) - 1, (1 << YW) - 1);
    tick();
    chk("wrap_drain_busy", 32'(busy), 1);
    chk("wrap_drain_cfg_ready", 32'(cfg_ready), 0);
    tick();
    chk("wrap_load_cfg_ready", 32'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
    ev((1 << XW) - 1, 10, 1'b0);
    tick();
    chk("wrap_max_pass", 32'(out_valid), 1);
    chk("wrap_max_x", 32'(out_x), (1 << XW) - 1);
    ev(0, 10, 1'b0);
    tick();
    exp_drops++;
    chk("wrap_zero_drop", 32'(out_valid), 0);
    chk("wrap_drop_cnt", 32'(drop_count), exp_drop());

    // Reset during LOAD abandons the pending window
    in_valid = 1'b0;
    cfg(200, 0, 10, 10);
    tick();
    tick();
    chk("rl_cfg_ready", 32'(cfg_ready), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rl_cfg_ready_rst", 32'(cfg_ready), 0);
    chk("rl_busy_rst", 32'(busy), 0);
    chk("rl_out_x_rst", 32'(out_x), 0);
    chk("rl_out_valid_rst", 32'(out_valid), 0);
    chk("rl_drop_rst", 32'(drop_count), 0);
    exp_drops = 0;
    cfg_valid = 1'b0;
    #2 rst_n = 1'b1;
    ev(50, 50, 1'b1);
    tick();
    chk("rl_def_pass", 32'(out_valid), 1);
    chk("rl_def_x", 32'(out_x), 50);
    ev(150, 50, 1'b0);
    tick();
    exp_drops++;
    chk("rl_def_drop", 32'(out_valid), 0);
    chk("rl_drop_cnt", 32'(drop_count), exp_drop());

    // Drop counter saturation
    ev(200, 200, 1'b0);
    repeat (20) tick();
    exp_drops += 20;
    in_valid = 1'b0;
    chk("sat_drop_cnt", 32'(drop_count), exp_drop());
    chk("sat_out_valid", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
